// File: rtl/sram_stream_reader.sv
// sram_stream_reader: reads a block of consecutive words from a 1-cycle-latency
// synchronous SRAM and presents them as a valid/ready stream with a last flag.
// A 2-entry skid FIFO absorbs the read latency so the stream can run at one
// word per cycle while still honouring downstream back-pressure.
// Optional feature: define SRAM_RD_ERR_EN to add an err output that rejects
// zero-length or address-overflowing requests instead of wrapping.
module sram_stream_reader #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  output logic              busy,
  output logic              done,
  output logic              sram_csb,
  output logic              sram_wsb,
  output logic [ADDR_W-1:0] sram_raddr,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last
`ifdef SRAM_RD_ERR_EN
  ,
  output logic              err
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   raddr_q, raddr_d;          // address of the next read to issue
  logic [ADDR_W:0]     remain_q, remain_d;        // reads still to be issued
  logic                inflight_q, inflight_d;    // a read was issued last cycle
  logic                inflight_last_q, inflight_last_d;
  logic [1:0]          occ_q, occ_d;              // FIFO occupancy (0..2)
  logic                rd_ptr_q, rd_ptr_d;
  logic                wr_ptr_q, wr_ptr_d;
  logic [DATA_W-1:0]   fifo_data_q [2];
  logic                fifo_last_q [2];

  logic                start_ok;
  logic                push;
  logic                pop;
  logic                issue;
  logic [1:0]          pending;

`ifdef SRAM_RD_ERR_EN
  localparam logic [ADDR_W+1:0] DEPTH = {2'b01, {ADDR_W{1'b0}}};
  logic                range_bad;
  logic [ADDR_W+1:0]   end_addr;
  logic                err_q, err_d;
`endif

  // Request acceptance and read-issue qualification.
  always_comb begin
`ifdef SRAM_RD_ERR_EN
    end_addr  = {2'b00, base_addr} + {1'b0, length};
    range_bad = (length == '0) || (end_addr > DEPTH);
    start_ok  = start && (state_q == IDLE) && !range_bad;
    err_d     = start && (state_q == IDLE) && range_bad;
`else
    start_ok  = start && (state_q == IDLE) && (length != '0);
`endif
    push    = inflight_q;
    pop     = out_valid && out_ready;
    pending = occ_q + {1'b0, inflight_q};
    // Issue only while the FIFO is guaranteed a free slot when the data lands.
    issue   = (state_q == RUN) && (remain_q != '0) && ((pending < 2'd2) || pop);
  end

  // Next-state logic for the FSM, address/count tracking and FIFO pointers.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d         = state_q;
    raddr_d         = raddr_q;
    remain_d        = remain_q;
    inflight_d      = issue;
    inflight_last_d = issue && (remain_q == {{ADDR_W{1'b0}}, 1'b1});
    occ_d           = occ_q + {1'b0, push} - {1'b0, pop};
    wr_ptr_d        = wr_ptr_q ^ push;
    rd_ptr_d        = rd_ptr_q ^ pop;
    unique case (state_q)
      IDLE: begin
        if (start_ok) begin
          state_d  = RUN;
          raddr_d  = base_addr;
          remain_d = length;
        end
      end
      RUN: begin
        if (issue) begin
          raddr_d  = raddr_q + 1'b1;
          remain_d = remain_q - 1'b1;
          if (remain_q == {{ADDR_W{1'b0}}, 1'b1}) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if ((occ_q == 2'd0) && !inflight_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state registers; reset also discards any read still in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      raddr_q         <= '0;
      remain_q        <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      occ_q           <= 2'd0;
      rd_ptr_q        <= 1'b0;
      wr_ptr_q        <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples values from before the edge, independent of statement order.
      state_q         <= state_d;
      raddr_q         <= raddr_d;
      remain_q        <= remain_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
      occ_q           <= occ_d;
      rd_ptr_q        <= rd_ptr_d;
      wr_ptr_q        <= wr_ptr_d;
    end
  end

  // FIFO storage captures SRAM data the cycle after each issue.
  always_ff @(posedge clk) begin
    // NOTE: the data array is deliberately not reset; occupancy is, and the
    // outputs are gated by out_valid, so stale contents are never visible.
    if (push) begin
      fifo_data_q[wr_ptr_q] <= sram_rdata;
      fifo_last_q[wr_ptr_q] <= inflight_last_q;
    end
  end

`ifdef SRAM_RD_ERR_EN
  // One-cycle rejection pulse for a malformed request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end
  assign err = err_q;
`endif

  // Output decode; all terms come from registers except the pop-qualified issue.
  always_comb begin
    busy       = (state_q != IDLE);
    done       = (state_q == DRAIN) && (occ_q == 2'd0) && !inflight_q;
    sram_csb   = ~issue;
    sram_wsb   = 1'b1;
    sram_raddr = raddr_q;
    out_valid  = (occ_q != 2'd0);
    out_data   = out_valid ? fifo_data_q[rd_ptr_q] : '0;
    out_last   = out_valid ? fifo_last_q[rd_ptr_q] : 1'b0;
  end

endmodule

// File: tb/tb_sram_stream_reader.sv
// Directed testbench for sram_stream_reader with a behavioural SRAM
// (mem[i] = i, one-cycle read latency) and a negedge stream monitor.
module tb_sram_stream_reader;

  localparam int DATA_W = 64;
  localparam int ADDR_W = 6;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W:0]   length;
  logic              busy;
  logic              done;
  logic              sram_csb;
  logic              sram_wsb;
  logic [ADDR_W-1:0] sram_raddr;
  logic [DATA_W-1:0] sram_rdata = '0;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
`ifdef SRAM_RD_ERR_EN
  logic              err;
`endif

  sram_stream_reader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .base_addr  (base_addr),
    .length     (length),
    .busy       (busy),
    .done       (done),
    .sram_csb   (sram_csb),
    .sram_wsb   (sram_wsb),
    .sram_raddr (sram_raddr),
    .sram_rdata (sram_rdata),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last)
`ifdef SRAM_RD_ERR_EN
    ,
    .err        (err)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural SRAM: data appears the cycle after a read issue.
  logic [DATA_W-1:0] mem [64];
  initial for (int i = 0; i < 64; i++) mem[i] = DATA_W'(i);
  always @(posedge clk) if (!sram_csb) sram_rdata <= mem[sram_raddr];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int start_cyc;

  always @(posedge clk) cyc++;

  // Monitor state
  int                outstanding = 0;
  int                ovf_viol = 0;
  int                hold_viol = 0;
  int                done_cnt = 0;
  int                done_cyc = 0;
  int                err_cnt = 0;
  int                busy_seen = 0;
  bit                mon_pop;
  bit                stall_prev = 0;
  logic [DATA_W-1:0] stall_data;
  logic              stall_last;
  logic [ADDR_W-1:0] addr_log [$];
  logic [DATA_W-1:0] data_log [$];
  logic              last_log [$];
  int                pop_cyc_log [$];

  always @(negedge clk) begin
    if (!rst_n) begin
      outstanding = 0;
      stall_prev  = 0;
    end else begin
      mon_pop = out_valid && out_ready;
      if (!sram_csb && outstanding >= 2 && !mon_pop) ovf_viol++;
      if (!sram_csb) addr_log.push_back(sram_raddr);
      if (mon_pop) begin
        data_log.push_back(out_data);
        last_log.push_back(out_last);
        pop_cyc_log.push_back(cyc);
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (busy) busy_seen++;
`ifdef SRAM_RD_ERR_EN
      if (err) err_cnt++;
`endif
      if (stall_prev && (!out_valid || out_data !== stall_data || out_last !== stall_last))
        hold_viol++;
      stall_prev  = out_valid && !out_ready;
      stall_data  = out_data;
      stall_last  = out_last;
      outstanding = outstanding + (sram_csb ? 0 : 1) - (mon_pop ? 1 : 0);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    addr_log.delete();
    data_log.delete();
    last_log.delete();
    pop_cyc_log.delete();
    ovf_viol  = 0;
    hold_viol = 0;
    done_cnt  = 0;
    err_cnt   = 0;
    busy_seen = 0;
  endtask

  task automatic do_start(input logic [ADDR_W-1:0] b, input logic [ADDR_W:0] l);
    start     = 1'b1;
    base_addr = b;
    length    = l;
    start_cyc = cyc;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit toggle);
    for (int i = 0; i < budget; i++) begin
      if (done_cnt > 0) break;
      if (toggle) out_ready = ~out_ready;
      tick(1);
    end
    checks++;
    if (done_cnt == 0) begin
      failures++;
      $display("FAIL done_timeout: no done within %0d cycles", budget);
    end
    out_ready = 1'b1;
    tick(4);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; base_addr = '0; length = '0; out_ready = 1'b1;
    tick(3);
    checks++;
    if ({busy, done, sram_csb, sram_wsb, out_valid, out_last} !== 6'b001100) begin
      failures++;
      $display("FAIL reset_ctrl: got %b exp 001100", {busy, done, sram_csb, sram_wsb, out_valid, out_last});
    end
    checks++;
    if (sram_raddr !== '0 || out_data !== '0) begin
      failures++;
      $display("FAIL reset_data: raddr %0d data %0h exp 0 0", sram_raddr, out_data);
    end
    rst_n = 1'b1;
    tick(3);
    checks++;
    if ({busy, done, sram_csb, out_valid} !== 4'b0010) begin
      failures++;
      $display("FAIL post_reset: got %b exp 0010", {busy, done, sram_csb, out_valid});
    end
  endtask

  task automatic test_basic();
    clear_logs();
    out_ready = 1'b1;
    do_start(6'd0, 7'd4);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL basic_busy: got %b exp 1", busy);
    end
    wait_done(40, 1'b0);
    checks++;
    if (data_log.size() != 4) begin
      failures++;
      $display("FAIL basic_count: got %0d exp 4", data_log.size());
    end
    for (int i = 0; i < data_log.size() && i < 4; i++) begin
      checks++;
      if (data_log[i] !== DATA_W'(i) || last_log[i] !== (i == 3) ||
          pop_cyc_log[i] != start_cyc + 3 + i || addr_log[i] !== ADDR_W'(i)) begin
        failures++;
        $display("FAIL basic_word%0d: data %0d last %b cyc %0d addr %0d exp %0d %b %0d %0d",
                 i, data_log[i], last_log[i], pop_cyc_log[i], addr_log[i],
                 i, (i == 3), start_cyc + 3 + i, i);
      end
    end
    checks++;
    if (done_cnt != 1 || done_cyc != start_cyc + 7) begin
      failures++;
      $display("FAIL basic_done: count %0d cyc %0d exp 1 %0d", done_cnt, done_cyc, start_cyc + 7);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL basic_idle: busy %b exp 0", busy);
    end
  endtask

  task automatic test_zero_length();
    clear_logs();
    do_start(6'd3, 7'd0);
    tick(6);
    checks++;
    if (addr_log.size() != 0 || busy_seen != 0 || done_cnt != 0) begin
      failures++;
      $display("FAIL zero_len: reads %0d busy %0d done %0d exp 0 0 0",
               addr_log.size(), busy_seen, done_cnt);
    end
`ifdef SRAM_RD_ERR_EN
    checks++;
    if (err_cnt != 1) begin
      failures++;
      $display("FAIL zero_len_err: pulses %0d exp 1", err_cnt);
    end
`endif
  endtask

  task automatic test_stall();
    clear_logs();
    out_ready = 1'b1;
    do_start(6'd10, 7'd8);
    wait_done(80, 1'b1);
    checks++;
    if (data_log.size() != 8) begin
      failures++;
      $display("FAIL stall_count: got %0d exp 8", data_log.size());
    end
    for (int i = 0; i < data_log.size() && i < 8; i++) begin
      checks++;
      if (data_log[i] !== DATA_W'(10 + i) || last_log[i] !== (i == 7)) begin
        failures++;
        $display("FAIL stall_word%0d: data %0d last %b exp %0d %b",
                 i, data_log[i], last_log[i], 10 + i, (i == 7));
      end
    end
    checks++;
    if (hold_viol != 0 || ovf_viol != 0 || done_cnt != 1) begin
      failures++;
      $display("FAIL stall_rules: hold %0d overflow %0d done %0d exp 0 0 1",
               hold_viol, ovf_viol, done_cnt);
    end
  endtask

  task automatic test_wrap();
    clear_logs();
    out_ready = 1'b1;
    do_start(6'd62, 7'd4);
`ifdef SRAM_RD_ERR_EN
    tick(6);
    checks++;
    if (err_cnt != 1 || addr_log.size() != 0 || busy_seen != 0 || done_cnt != 0) begin
      failures++;
      $display("FAIL wrap_err: err %0d reads %0d busy %0d done %0d exp 1 0 0 0",
               err_cnt, addr_log.size(), busy_seen, done_cnt);
    end
`else
    wait_done(40, 1'b0);
    checks++;
    if (data_log.size() != 4 || addr_log.size() != 4) begin
      failures++;
      $display("FAIL wrap_count: data %0d reads %0d exp 4 4", data_log.size(), addr_log.size());
    end
    for (int i = 0; i < data_log.size() && i < 4 && i < addr_log.size(); i++) begin
      checks++;
      if (addr_log[i] !== ADDR_W'((62 + i) % 64) || data_log[i] !== DATA_W'((62 + i) % 64)) begin
        failures++;
        $display("FAIL wrap_word%0d: addr %0d data %0d exp %0d", i, addr_log[i], data_log[i],
                 (62 + i) % 64);
      end
    end
`endif
  endtask

  task automatic test_back_to_back();
    clear_logs();
    out_ready = 1'b1;
    do_start(6'd20, 7'd6);
    tick(1);
    do_start(6'd40, 7'd3);
    wait_done(40, 1'b0);
    tick(4);
    checks++;
    if (data_log.size() != 6 || addr_log.size() != 6 || done_cnt != 1) begin
      failures++;
      $display("FAIL busy_start: data %0d reads %0d done %0d exp 6 6 1",
               data_log.size(), addr_log.size(), done_cnt);
    end
    for (int i = 0; i < data_log.size() && i < 6; i++) begin
      checks++;
      if (data_log[i] !== DATA_W'(20 + i) || last_log[i] !== (i == 5)) begin
        failures++;
        $display("FAIL busy_word%0d: data %0d last %b exp %0d %b",
                 i, data_log[i], last_log[i], 20 + i, (i == 5));
      end
    end
  endtask

  task automatic test_reset_mid();
    clear_logs();
    out_ready = 1'b0;
    do_start(6'd30, 7'd8);
    tick(5);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, sram_csb, out_valid, out_last} !== 5'b00100 ||
        out_data !== '0 || sram_raddr !== '0) begin
      failures++;
      $display("FAIL midreset_outputs: ctrl %b data %0h raddr %0d exp 00100 0 0",
               {busy, done, sram_csb, out_valid, out_last}, out_data, sram_raddr);
    end
    tick(2);
    rst_n = 1'b1;
    tick(2);
    clear_logs();
    out_ready = 1'b1;
    do_start(6'd5, 7'd2);
    wait_done(40, 1'b0);
    checks++;
    if (data_log.size() != 2 || done_cnt != 1) begin
      failures++;
      $display("FAIL midreset_count: data %0d done %0d exp 2 1", data_log.size(), done_cnt);
    end
    for (int i = 0; i < data_log.size() && i < 2; i++) begin
      checks++;
      if (data_log[i] !== DATA_W'(5 + i) || last_log[i] !== (i == 1)) begin
        failures++;
        $display("FAIL midreset_word%0d: data %0d last %b exp %0d %b",
                 i, data_log[i], last_log[i], 5 + i, (i == 1));
      end
    end
  endtask

  task automatic test_full_block();
    int last_cnt;
    clear_logs();
    out_ready = 1'b1;
    do_start(6'd0, 7'd64);
    wait_done(200, 1'b0);
    checks++;
    if (data_log.size() != 64) begin
      failures++;
      $display("FAIL full_count: got %0d exp 64", data_log.size());
    end
    last_cnt = 0;
    for (int i = 0; i < data_log.size() && i < 64; i++) begin
      if (last_log[i]) last_cnt++;
      checks++;
      if (data_log[i] !== DATA_W'(i) || pop_cyc_log[i] != start_cyc + 3 + i) begin
        failures++;
        $display("FAIL full_word%0d: data %0d cyc %0d exp %0d %0d",
                 i, data_log[i], pop_cyc_log[i], i, start_cyc + 3 + i);
      end
    end
    checks++;
    if (last_cnt != 1 || data_log.size() != 64 || last_log[63] !== 1'b1) begin
      failures++;
      $display("FAIL full_last: count %0d exp 1 on word 63", last_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_length();
    test_stall();
    test_wrap();
    test_back_to_back();
    test_reset_mid();
    test_full_block();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
